// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with two-flop input synchroniser and mid-bit sampling
module uart_rx #(
    parameter int CLK_FREQ        = 100_000_000,
    parameter int BAUDRATE        = 115_200,
    parameter int DATA_BIT_LENGTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       data_rx,
    output logic [DATA_BIT_LENGTH-1:0] data_out,
    output logic                       data_out_done,
    output logic                       frame_error
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW           = $clog2(DATA_BIT_LENGTH);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BIT_LENGTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 sync_q;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [DATA_BIT_LENGTH-1:0] shift_q, shift_d;
    logic [DATA_BIT_LENGTH-1:0] dout_q, dout_d;
    logic                       done_q, done_d;
    logic                       ferr_q, ferr_d;
    logic                       rx_s;

    assign rx_s          = sync_q[1];
    assign data_out      = dout_q;
    assign data_out_done = done_q;
    assign frame_error   = ferr_q;

    // state, counters and outputs; synchroniser resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], data_rx};
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // frame sequencing: half-bit to mid-start, then one full bit per sample
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? IDLE : START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q == IDX_LAST ? '0 : idx_q + IW'(1);
                    state_d        = idx_q == IDX_LAST ? STOP : DATA;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    dout_d  = rx_s ? shift_q : dout_q;
                    done_d  = rx_s;
                    ferr_d  = !rx_s;
                    state_d = rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : WAIT_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a byte-level receive model
module tb_uart_rx;
    localparam int CF  = 100_000_000;
    localparam int BR  = 6_250_000;
    localparam int CPB = CF / BR;
    localparam int HB  = CPB / 2;
    localparam int NB  = 8;
    localparam int BIT = CPB * 10;
    localparam int LAT = 2 + HB + (NB + 1) * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          data_rx = 1'b1;
    logic [NB-1:0] data_out;
    logic          data_out_done;
    logic          frame_error;

    int total = 0;
    int bad = 0;

    logic [NB-1:0] got[$];
    int n_done = 0, n_ferr = 0, n_double = 0, n_spur = 0, done_cyc = 0, cyc = 0;
    logic          prev_done = 1'b0, prev_ferr = 1'b0;
    logic [NB-1:0] prev_out = '0;

    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] last_good = '0;
    int exp_ferr = 0;

    uart_rx #(.CLK_FREQ(CF), .BAUDRATE(BR), .DATA_BIT_LENGTH(NB)) dut (
        .clk(clk), .rst_n(rst_n), .data_rx(data_rx),
        .data_out(data_out), .data_out_done(data_out_done), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_out_done) begin
            got.push_back(data_out);
            n_done++;
            done_cyc = cyc;
        end
        if (frame_error) n_ferr++;
        if ((data_out_done && prev_done) || (frame_error && prev_ferr)) n_double++;
        if (rst_n && !data_out_done && data_out !== prev_out) n_spur++;
        prev_done = data_out_done;
        prev_ferr = frame_error;
        prev_out  = data_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [NB-1:0] b, input logic stop);
        if (stop) begin
            exp_q.push_back(b);
            last_good = b;
        end else exp_ferr++;
    endtask

    task automatic send(input logic [NB-1:0] b, input logic stop, input int bn);
        data_rx = 1'b0;
        #(bn);
        for (int i = 0; i < NB; i++) begin
            data_rx = b[i];
            #(bn);
        end
        data_rx = stop;
        #(bn);
        if (!stop) begin
            #(2 * bn);
            data_rx = 1'b1;
            #(bn);
        end
        model(b, stop);
    endtask

    task automatic verify(input string tag);
        @(negedge clk);
        chk({tag, " done_count"}, n_done, exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), got[i], exp_q[i]);
        chk({tag, " data_out"}, data_out, last_good);
        chk({tag, " ferr_count"}, n_ferr, exp_ferr);
        chk({tag, " strobe_width"}, n_double, 0);
        chk({tag, " spurious_change"}, n_spur, 0);
    endtask

    initial begin
        int lat, bn, gap;
        logic [NB-1:0] b;
        logic stop;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset data_out", data_out, 0);
        chk("reset done", data_out_done, 0);
        chk("reset ferr", frame_error, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        @(posedge clk);
        #1;
        lat = cyc;
        send(8'h55, 1'b1, BIT + 1);
        lat = done_cyc - lat;
        #(BIT);
        verify("f55");
        chk("latency_in_window", lat >= LAT - 2 && lat <= LAT + 2, 1);

        send(8'hA3, 1'b1, BIT + 1);
        #(BIT);
        verify("fA3");
        chk("two_pulses", n_done, 2);

        send(8'h00, 1'b1, BIT + 1);
        send(8'hFF, 1'b1, BIT + 1);
        #(BIT);
        verify("b2b");

        data_rx = 1'b0;
        #(HB * 10 / 2);
        data_rx = 1'b1;
        #(3 * BIT);
        verify("glitch");
        send(8'h3C, 1'b1, BIT + 1);
        #(BIT);
        verify("f3C");

        send(8'h99, 1'b0, BIT + 1);
        verify("stop_low");
        send(8'h5A, 1'b1, BIT + 1);
        #(BIT);
        verify("f5A");

        data_rx = 1'b0;
        #(BIT);
        for (int i = 0; i < 4; i++) begin
            data_rx = i[0];
            #(BIT);
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midreset data_out", data_out, 0);
        chk("midreset done", data_out_done, 0);
        chk("midreset ferr", frame_error, 0);
        data_rx = 1'b1;
        last_good = '0;
        rst_n = 1'b1;
        #(2 * BIT);
        verify("abort");
        send(8'hC3, 1'b1, BIT + 1);
        #(BIT);
        verify("fC3");

        for (int k = 0; k < 24; k++) begin
            b    = NB'($urandom);
            stop = $urandom_range(0, 5) != 0;
            bn   = BIT - 3 + int'($urandom_range(0, 6));
            gap  = int'($urandom_range(0, 2));
            send(b, stop, bn);
            #(gap * bn);
        end
        #(2 * BIT);
        verify("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
